serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Digit-serial, multi-cycle add/subtract unit, parametrised in operand width and digit width.
- Processes DIGIT bits per clock, LSB digit first, using one DIGIT-wide ripple slice and a registered carry.
- Trades latency for area; for datapaths where a full-width ripple chain is too long or too large.
- Start/done handshake; adds subtract mode, borrow-in and signed-overflow flag.

Parameters:
- WIDTH, 16, operand/result width in bits.
- DIGIT, 4, bits processed per cycle; must divide WIDTH exactly. NDIG = WIDTH/DIGIT.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- sub  in  1  0: a+b+cin; 1: a-b-cin. Sampled with start.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- cin  in  1  carry-in (add) / borrow-in (sub), sampled with start.
- ready  out  1  high in IDLE only.
- busy  out  1  high in LOAD/RUN.
- done  out  1  one-cycle pulse: result valid.
- s  out  WIDTH  result; holds last completed value.
- cout  out  1  carry-out; in sub mode 1 = no borrow, 0 = borrow.
- ovf  out  1  signed overflow of the last completed operation.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, s=0, cout=0, ovf=0, done=0, busy=0, digit counter=0. ready=1 from the next cycle.
- Reset mid-operation: aborts; no done pulse; s/cout/ovf go to 0.
- IDLE: ready=1. At an edge with start=1:
  - latch a, and b or ~b according to sub;
  - latch carry = cin XOR sub;
  - go to RUN with counter=0.
- start=1 while ready=0 is ignored; no queueing.
- Operand inputs may change after the accepting edge.
- RUN: each edge adds digit[counter] of A and B' plus the carry register.
  - Sum digit shifts into the internal result register from the MSB side.
  - Carry register updates; counter increments.
- Final digit (counter=NDIG-1): that edge loads s, cout and ovf, and sets state=DONE.
  - cout = final carry.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start high in cycle 0 gives done=1 in cycle NDIG+1 (5 for defaults). Minimum start-to-start spacing is NDIG+2 cycles.
- Arithmetic: modulo 2^WIDTH, two's complement.
  - sub with cin=1 gives a-b-1.
  - No sign extension anywhere.
- s/cout/ovf change only at the final-digit edge or on reset; stable at all other times.
- NDIG=1 is legal: single RUN cycle, latency 2.
- DIGIT=1 is legal: bit-serial, latency WIDTH+1.
- busy = not ready and not done.

Decomposition:
- Shared package: state enum (IDLE, RUN, DONE), NDIG derivation, counter width = clog2(NDIG) with minimum 1.
- No LOAD state is needed; loading happens in the IDLE->RUN edge.
- One sub-module: digit_adder, a combinational DIGIT-wide ripple slice built from the existing full_adder cell.
  - Outputs: sum, carry out, and carry into its MSB (for ovf).
- The FSM, shift registers and counter live in serial_adder.

Test Plan (WIDTH=16, DIGIT=4 unless stated):
1. a=0x1234, b=0x4321, cin=0, sub=0 -> s=0x5555, cout=0, ovf=0; done exactly in cycle 5; ready low in cycles 1-5.
2. a=0xFFFF, b=0x0001, add -> s=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> s=0x8000, cout=0, ovf=1.
3. Subtract: a=0x0005, b=0x0007, sub=1, cin=0 -> s=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, cout=1, ovf=1. Then a=0x0005, b=0x0002, sub=1, cin=1 -> s=0x0002, cout=1.
4. Handshake:
   - Pulse start in cycle 2 of an operation with different operands -> ignored; first result unchanged.
   - Issue a second start on the first cycle ready=1 again -> correct result, no lost or duplicate done.
   - s must hold its value between operations.
5. Assert rst for one cycle during RUN (counter=2) -> no done; s=0, cout=0, ovf=0; ready=1 next cycle. A following operation completes correctly.
6. Parameter sweep:
   - DIGIT=16 (latency 2) and DIGIT=1 (latency 17).
   - WIDTH=8, DIGIT=2: random 1000 operations each, all sub/cin combinations.
   - Check against a+b+cin / a-b-cin modulo 2^WIDTH, with reference cout and ovf.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial add/subtract unit.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned ndig_of(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  // Digit counter width; a single-digit configuration still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned ndig);
    return (ndig < 2) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-wide ripple slice; also exposes the carry into its MSB.
module digit_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co,
  output logic             cmsb
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign co   = c[DIGIT];
  assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract unit: one DIGIT-wide slice per clock, LSB digit first.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NDIG = ndig_of(WIDTH, DIGIT);
  localparam int unsigned CW   = cnt_width(NDIG);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0]       dsum;
  logic                   dco;
  logic                   dcm;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [WIDTH-1:0]       res_nxt;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0]),
    .ci   (carry),
    .sum  (dsum),
    .co   (dco),
    .cmsb (dcm)
  );

  // New sum digit enters from the MSB side so the LSB digit ends up at bit 0.
  assign cat     = {dsum, res};
  assign res_nxt = cat[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= cin ^ sub;
            res   <= '0;
            cnt   <= '0;
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          res   <= res_nxt;
          carry <= dco;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(NDIG - 1)) begin
            s     <= res_nxt;
            cout  <= dco;
            ovf   <= dco ^ dcm;
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Randomised self-checking bench for serial_adder across four width/digit configurations.
module tb_serial_adder;

  localparam int NI = 4;
  localparam int WD [NI] = '{16, 16, 16, 8};
  localparam int ND [NI] = '{4, 1, 16, 4};

  logic        clk = 1'b0;
  logic        rst_i   [NI];
  logic        start_i [NI];
  logic        sub_i   [NI];
  logic        cin_i   [NI];
  logic [15:0] a_i     [NI];
  logic [15:0] b_i     [NI];

  wire         ready_o [NI];
  wire         busy_o  [NI];
  wire         done_o  [NI];
  wire         cout_o  [NI];
  wire         ovf_o   [NI];
  wire  [15:0] s_o     [NI];
  wire  [7:0]  s8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst_i[0]), .start(start_i[0]), .sub(sub_i[0]), .a(a_i[0]), .b(b_i[0]),
    .cin(cin_i[0]), .ready(ready_o[0]), .busy(busy_o[0]), .done(done_o[0]), .s(s_o[0]),
    .cout(cout_o[0]), .ovf(ovf_o[0]));

  serial_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst(rst_i[1]), .start(start_i[1]), .sub(sub_i[1]), .a(a_i[1]), .b(b_i[1]),
    .cin(cin_i[1]), .ready(ready_o[1]), .busy(busy_o[1]), .done(done_o[1]), .s(s_o[1]),
    .cout(cout_o[1]), .ovf(ovf_o[1]));

  serial_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst_i[2]), .start(start_i[2]), .sub(sub_i[2]), .a(a_i[2]), .b(b_i[2]),
    .cin(cin_i[2]), .ready(ready_o[2]), .busy(busy_o[2]), .done(done_o[2]), .s(s_o[2]),
    .cout(cout_o[2]), .ovf(ovf_o[2]));

  serial_adder #(.WIDTH(8), .DIGIT(2)) u_w8 (
    .clk(clk), .rst(rst_i[3]), .start(start_i[3]), .sub(sub_i[3]), .a(a_i[3][7:0]),
    .b(b_i[3][7:0]), .cin(cin_i[3]), .ready(ready_o[3]), .busy(busy_o[3]), .done(done_o[3]),
    .s(s8), .cout(cout_o[3]), .ovf(ovf_o[3]));

  assign s_o[3] = {8'h00, s8};

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: integer arithmetic on the true values, reduced modulo 2^w.
  function automatic void model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                input logic sv, input logic cv, output logic [15:0] es,
                                output logic ec, output logic eo);
    longint m, ua, ub, c, r, sa, sb, t;
    m  = longint'(1) << w;
    ua = longint'(av) & (m - 1);
    ub = longint'(bv) & (m - 1);
    c  = longint'(cv);
    if (!sv) begin
      r  = ua + ub + c;
      ec = (r >= m);
    end else begin
      r  = ua - ub - c;
      ec = (r >= 0);
    end
    es = 16'(r & (m - 1));
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    t  = sv ? sa - sb - c : sa + sb + c;
    eo = (t < -(m / 2)) || (t >= m / 2);
  endfunction

  task automatic do_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                       input logic sv, input logic cv, input bit glitch);
    logic [15:0] es, prev;
    logic        ec, eo;
    int          n;
    bit          seen;
    model(WD[k], av, bv, sv, cv, es, ec, eo);
    n = 0;
    while (!ready_o[k] && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("ready_wait", 32'(ready_o[k]), 1);
    prev = s_o[k];
    @(negedge clk);
    start_i[k] = 1'b1; a_i[k] = av; b_i[k] = bv; sub_i[k] = sv; cin_i[k] = cv;
    @(posedge clk);
    @(negedge clk);
    start_i[k] = 1'b0;
    a_i[k] = 16'($urandom); b_i[k] = 16'($urandom);
    sub_i[k] = 1'($urandom); cin_i[k] = 1'($urandom);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 100) begin
      @(posedge clk); #1; n++;
      if (done_o[k]) seen = 1'b1;
      else begin
        check("ready_low", 32'(ready_o[k]), 0);
        check("busy_high", 32'(busy_o[k]), 1);
        check("s_hold", 32'(s_o[k]), 32'(prev));
      end
      if (glitch && n == 1) begin
        @(negedge clk); start_i[k] = 1'b1; a_i[k] = 16'($urandom); b_i[k] = 16'($urandom);
      end
      if (glitch && n == 2) begin
        @(negedge clk); start_i[k] = 1'b0;
      end
    end
    check("done_seen", 32'(seen), 1);
    check("latency", n, ND[k]);
    check("s", 32'(s_o[k]), 32'(es));
    check("cout", 32'(cout_o[k]), 32'(ec));
    check("ovf", 32'(ovf_o[k]), 32'(eo));
    check("ready_at_done", 32'(ready_o[k]), 0);
    check("busy_at_done", 32'(busy_o[k]), 0);
    @(posedge clk); #1;
    check("done_pulse", 32'(done_o[k]), 0);
    check("ready_back", 32'(ready_o[k]), 1);
    check("s_after", 32'(s_o[k]), 32'(es));
  endtask

  // Start an operation and reset it while the digit counter is at 2.
  task automatic reset_mid(input int k);
    @(negedge clk);
    start_i[k] = 1'b1; a_i[k] = 16'h1234; b_i[k] = 16'h4321; sub_i[k] = 1'b0; cin_i[k] = 1'b0;
    @(posedge clk);
    @(negedge clk); start_i[k] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); rst_i[k] = 1'b1;
    @(posedge clk); #1;
    check("rst_done", 32'(done_o[k]), 0);
    check("rst_s", 32'(s_o[k]), 0);
    check("rst_cout", 32'(cout_o[k]), 0);
    check("rst_ovf", 32'(ovf_o[k]), 0);
    check("rst_ready", 32'(ready_o[k]), 1);
    check("rst_busy", 32'(busy_o[k]), 0);
    @(negedge clk); rst_i[k] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("rst_no_done", 32'(done_o[k]), 0);
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_i[k] = 1'b1; start_i[k] = 1'b0; sub_i[k] = 1'b0; cin_i[k] = 1'b0;
      a_i[k] = '0; b_i[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) rst_i[k] = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) begin
      check("reset_ready", 32'(ready_o[k]), 1);
      check("reset_busy", 32'(busy_o[k]), 0);
      check("reset_done", 32'(done_o[k]), 0);
      check("reset_s", 32'(s_o[k]), 0);
      check("reset_cout", 32'(cout_o[k]), 0);
      check("reset_ovf", 32'(ovf_o[k]), 0);
    end

    do_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    do_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(0, 16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0);
    do_op(0, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
    do_op(0, 16'h0005, 16'h0002, 1'b1, 1'b1, 1'b0);
    do_op(0, 16'hABCD, 16'h1111, 1'b0, 1'b1, 1'b1);
    do_op(0, 16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 1'b0);
    reset_mid(0);
    do_op(0, 16'h1234, 16'h4321, 1'b0, 1'b1, 1'b0);

    for (int k = 0; k < 3; k++) begin
      do_op(k, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      do_op(k, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 150; i++)
        do_op(k, 16'($urandom), 16'($urandom), 1'(i >> 1), 1'(i), 1'b0);
    end

    do_op(3, 16'h007F, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(3, 16'h0080, 16'h0001, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++)
      do_op(3, 16'($urandom), 16'($urandom), 1'(i >> 1), 1'(i), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
